fb_port_arbiter: RTL and testbench

- Shares one single-port, double-banked frame buffer RAM (2 x 76800 x 24-bit, 320x240) between two masters:
  - the VGA display read port, which scans the front bank;
  - a pixel writer (drawing engine or camera path), which fills the back bank.
- Display reads have absolute priority. Writer uses a valid/ready handshake.
- A swap-request FSM exchanges front and back banks only at the vertical-sync boundary, so the display never tears.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_swap_fsm.sv | 50 +++++
 rtl/fb_port_arbiter.sv | 84 ++++++++
 tb/tb_fb_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame buffer geometry, pixel/address types and swap FSM states
// shared by the frame buffer port arbiter slice.
package fb_pkg;

    localparam int FB_W       = 320;
    localparam int FB_H       = 240;
    localparam int FB_DEPTH   = FB_W * FB_H;
    localparam int PIX_ADDR_W = 17;
    localparam int PIX_W      = 24;

    typedef logic [PIX_W-1:0]      pixel_t;
    typedef logic [PIX_ADDR_W-1:0] pix_addr_t;

    typedef enum logic [1:0] {IDLE, PENDING, SWAP} swap_state_t;

endpackage

// File: rtl/fb_swap_fsm.sv
// fb_swap_fsm: vertical-sync edge detector, bank swap request FSM and the
// front bank register; the bank only toggles on the cycle after a VS start.
module fb_swap_fsm
    import fb_pkg::*;
#(
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    input  logic swap_req,
    output logic vs_start,
    output logic idle,
    output logic swap_pending,
    output logic swap_done,
    output logic front_bank
);

    swap_state_t state, state_nxt;
    logic        vs_q;

    // XOR with the polarity turns both samples into "sync asserted" flags
    assign vs_start = (vs ^ VS_ACTIVE_LOW) & ~(vs_q ^ VS_ACTIVE_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vs_q       <= VS_ACTIVE_LOW;
            front_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            vs_q  <= vs;
            if (state == SWAP)
                front_bank <= ~front_bank;
        end
    end

    always_comb begin
        state_nxt = state == IDLE    ? (swap_req ? PENDING : IDLE) :
                    state == PENDING ? (vs_start ? SWAP : PENDING) :
                                       IDLE;
    end

    always_comb begin
        idle         = state == IDLE;
        swap_pending = state == PENDING;
        swap_done    = state == SWAP;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares a single-port double-banked frame buffer between the
// display read port (absolute priority) and a valid/ready pixel writer.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W        = 17,
    parameter int DATA_W        = 24,
    parameter int FB_DEPTH      = fb_pkg::FB_DEPTH,
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iVS,
    input  logic              iRd_en,
    input  logic [ADDR_W-1:0] iRd_addr,
    output logic [DATA_W-1:0] oRd_data,
    output logic              oRd_valid,
    input  logic              iWr_valid,
    input  logic [ADDR_W-1:0] iWr_addr,
    input  logic [DATA_W-1:0] iWr_data,
    output logic              oWr_ready,
    output logic              oWr_drop,
    input  logic              iSwap_req,
    output logic              oSwap_pending,
    output logic              oSwap_done,
    output logic              oFront_bank,
    output logic [15:0]       oStall_cnt,
    output logic [ADDR_W:0]   oMem_addr,
    output logic              oMem_wren,
    output logic [DATA_W-1:0] oMem_wdata,
    input  logic [DATA_W-1:0] iMem_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(FB_DEPTH);

    logic        idle, vs_start, accept, stall, rd_d1;
    logic [15:0] stall_acc, stall_base;

    fb_swap_fsm #(
        .VS_ACTIVE_LOW(VS_ACTIVE_LOW)
    ) u_swap (
        .clk         (iVGA_CLK),
        .rst_n       (iRST_n),
        .vs          (iVS),
        .swap_req    (iSwap_req),
        .vs_start    (vs_start),
        .idle        (idle),
        .swap_pending(oSwap_pending),
        .swap_done   (oSwap_done),
        .front_bank  (oFront_bank)
    );

    always_comb begin
        oWr_ready  = !iRd_en && idle;
        accept     = iWr_valid && oWr_ready;
        stall      = iWr_valid && !oWr_ready;
        oMem_addr  = iRd_en ? {oFront_bank, iRd_addr} : {~oFront_bank, iWr_addr};
        oMem_wren  = accept && iWr_addr < DEPTH;
        oMem_wdata = iWr_data;
        stall_base = vs_start ? 16'd0 : stall_acc;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rd_d1      <= 1'b0;
            oRd_valid  <= 1'b0;
            oRd_data   <= '0;
            oWr_drop   <= 1'b0;
            stall_acc  <= '0;
            oStall_cnt <= '0;
        end else begin
            rd_d1     <= iRd_en;
            oRd_valid <= rd_d1;
            if (rd_d1)
                oRd_data <= iMem_rdata;
            oWr_drop <= accept && iWr_addr >= DEPTH;
            // a stall in the vs_start cycle already belongs to the new frame
            stall_acc <= (stall && stall_base != 16'hFFFF) ? stall_base + 16'd1 : stall_base;
            if (vs_start)
                oStall_cnt <= stall_acc;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed scenarios against a behavioural 1-cycle-latency
// frame buffer RAM with hand-computed expectations.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b1;
    logic        rd_en = 1'b0;
    logic [16:0] rd_addr = 17'h10;
    logic        wr_valid = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic [23:0] rd_data, mem_wdata, mem_rdata;
    logic        rd_valid, wr_ready, wr_drop, swap_pending, swap_done, front_bank, mem_wren;
    logic [15:0] stall_cnt;
    logic [17:0] mem_addr;

    logic        pre_en = 1'b0;
    logic [17:0] pre_addr = '0;
    logic [23:0] pre_data = '0;
    logic [23:0] mem [0:262143];
    logic [17:0] ra_q;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_wren) mem[mem_addr] <= mem_wdata;
        ra_q <= mem_addr;
    end
    assign mem_rdata = mem[ra_q];

    fb_port_arbiter dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .iVS          (vs),
        .iRd_en       (rd_en),
        .iRd_addr     (rd_addr),
        .oRd_data     (rd_data),
        .oRd_valid    (rd_valid),
        .iWr_valid    (wr_valid),
        .iWr_addr     (wr_addr),
        .iWr_data     (wr_data),
        .oWr_ready    (wr_ready),
        .oWr_drop     (wr_drop),
        .iSwap_req    (swap_req),
        .oSwap_pending(swap_pending),
        .oSwap_done   (swap_done),
        .oFront_bank  (front_bank),
        .oStall_cnt   (stall_cnt),
        .oMem_addr    (mem_addr),
        .oMem_wren    (mem_wren),
        .oMem_wdata   (mem_wdata),
        .iMem_rdata   (mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [17:0] a, input logic [23:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick;
        pre_en = 1'b0;
    endtask

    task automatic test_reset;
        preload(18'h00010, 24'hA5B6C7);
        preload(18'h00020, 24'h111111);
        preload(18'h00021, 24'h222222);
        n_checks++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL reset_front: got %b want 0", front_bank); end
        n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", swap_pending); end
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", swap_done); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 24'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 000000", rd_data); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %h want 0000", stall_cnt); end
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", wr_drop); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_read;
        rd_en = 1'b1; rd_addr = 17'h10; wr_valid = 1'b1; wr_addr = 17'd100;
        #1;
        n_checks++; if (mem_addr !== 18'h00010) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 00010", mem_addr); end
        n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL rd_wren: got %b want 0", mem_wren); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rd_blocks_wr: got %b want 0", wr_ready); end
        tick;
        rd_en = 1'b0; wr_valid = 1'b0;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency1: got %b want 0", rd_valid); end
        tick;
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 24'hA5B6C7) begin n_fail++; $display("FAIL rd_data: got %h want a5b6c7", rd_data); end
        tick;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 24'hA5B6C7) begin n_fail++; $display("FAIL rd_data_hold: got %h want a5b6c7", rd_data); end
    endtask

    task automatic test_back_to_back;
        rd_en = 1'b1; rd_addr = 17'h20;
        tick;
        rd_addr = 17'h21;
        tick;
        rd_en = 1'b0;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 24'h111111) begin n_fail++; $display("FAIL b2b_first: got %b/%h want 1/111111", rd_valid, rd_data); end
        tick;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 24'h222222) begin n_fail++; $display("FAIL b2b_second: got %b/%h want 1/222222", rd_valid, rd_data); end
        tick;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", rd_valid); end
    endtask

    task automatic test_write;
        rd_en = 1'b0; wr_valid = 1'b1; wr_addr = 17'd100; wr_data = 24'h123456;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", wr_ready); end
        n_checks++; if (mem_wren !== 1'b1) begin n_fail++; $display("FAIL wr_wren: got %b want 1", mem_wren); end
        n_checks++; if (mem_addr !== {1'b1, 17'd100}) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 20064", mem_addr); end
        n_checks++; if (mem_wdata !== 24'h123456) begin n_fail++; $display("FAIL wr_wdata: got %h want 123456", mem_wdata); end
        tick;
        n_checks++; if (mem[18'h20064] !== 24'h123456) begin n_fail++; $display("FAIL wr_stored: got %h want 123456", mem[18'h20064]); end
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL wr_no_drop: got %b want 0", wr_drop); end
        wr_addr = 17'd76799; wr_data = 24'h0F0F0F;
        #1;
        n_checks++; if (mem_wren !== 1'b1) begin n_fail++; $display("FAIL wr_last_pixel: got %b want 1", mem_wren); end
        tick;
        wr_addr = 17'd76800; wr_data = 24'hABCDEF;
        #1;
        n_checks++; if (wr_ready !== 1'b1 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL wr_oob_wren: got ready %b wren %b want 1/0", wr_ready, mem_wren); end
        tick;
        wr_valid = 1'b0;
        n_checks++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL wr_drop_pulse: got %b want 1", wr_drop); end
        tick;
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL wr_drop_end: got %b want 0", wr_drop); end
    endtask

    task automatic test_swap;
        int bad = 0;
        wr_valid = 1'b1; wr_addr = 17'd5; swap_req = 1'b1;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL swap_req_idle_ready: got %b want 1", wr_ready); end
        tick;
        swap_req = 1'b0;
        for (int i = 0; i < 500; i++) begin
            n_checks++;
            if (swap_pending !== 1'b1 || wr_ready !== 1'b0 || front_bank !== 1'b0) begin
                n_fail++;
                $display("FAIL swap_window[%0d]: got pending %b ready %b front %b want 1/0/0", i, swap_pending, wr_ready, front_bank);
            end
            tick;
        end
        vs = 1'b0;
        tick;
        n_checks++; if (swap_done !== 1'b1 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL swap_done_cycle: got done %b pending %b want 1/0", swap_done, swap_pending); end
        n_checks++; if (front_bank !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL swap_before_toggle: got front %b ready %b want 0/0", front_bank, wr_ready); end
        tick;
        vs = 1'b1;
        n_checks++; if (swap_done !== 1'b0 || front_bank !== 1'b1) begin n_fail++; $display("FAIL swap_after: got done %b front %b want 0/1", swap_done, front_bank); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL swap_ready_back: got %b want 1", wr_ready); end
        wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (swap_done !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL swap_single_pulse: got %0d extra done cycles want 0", bad); end
    endtask

    task automatic test_reset_mid;
        rd_en = 1'b1; rd_addr = 17'h10;
        tick;
        tick;
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        n_checks++; if (swap_pending !== 1'b1 || front_bank !== 1'b1 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got pending %b front %b valid %b want 1/1/1", swap_pending, front_bank, rd_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL mid_front: got %b want 0", front_bank); end
        n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL mid_pending: got %b want 0", swap_pending); end
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 24'h0) begin n_fail++; $display("FAIL mid_rd: got %b/%h want 0/000000", rd_valid, rd_data); end
        rd_en = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_coincident;
        swap_req = 1'b1; vs = 1'b0;
        tick;
        swap_req = 1'b0;
        n_checks++; if (swap_pending !== 1'b1 || swap_done !== 1'b0) begin n_fail++; $display("FAIL coin_pending: got pending %b done %b want 1/0", swap_pending, swap_done); end
        tick;
        vs = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            n_checks++;
            if (front_bank !== 1'b0 || swap_done !== 1'b0 || swap_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL coin_hold[%0d]: got front %b done %b pending %b want 0/0/1", i, front_bank, swap_done, swap_pending);
            end
        end
        vs = 1'b0;
        tick;
        n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL coin_done: got %b want 1", swap_done); end
        tick;
        vs = 1'b1;
        n_checks++; if (front_bank !== 1'b1) begin n_fail++; $display("FAIL coin_front: got %b want 1", front_bank); end
        tick;
    endtask

    task automatic test_stall;
        vs = 1'b0;
        tick;
        vs = 1'b1;
        tick;
        rd_en = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick;
        rd_en = 1'b0; wr_valid = 1'b0; vs = 1'b0;
        tick;
        vs = 1'b1;
        n_checks++; if (stall_cnt !== 16'd300) begin n_fail++; $display("FAIL stall_300: got %0d want 300", stall_cnt); end
        tick;
        rd_en = 1'b1; wr_valid = 1'b1; vs = 1'b0;
        tick;
        rd_en = 1'b0; wr_valid = 1'b0; vs = 1'b1;
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_vs_cycle_prev: got %0d want 0", stall_cnt); end
        tick;
        vs = 1'b0;
        tick;
        vs = 1'b1;
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_vs_cycle_new: got %0d want 1", stall_cnt); end
        tick;
        rd_en = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 70000; i++) tick;
        rd_en = 1'b0; wr_valid = 1'b0; vs = 1'b0;
        tick;
        vs = 1'b1;
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_saturate: got %h want ffff", stall_cnt); end
        tick;
    endtask

    initial begin
        test_reset;
        test_read;
        test_back_to_back;
        test_write;
        test_swap;
        test_reset_mid;
        test_coincident;
        test_stall;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
